// File: rtl/snake_pkg.sv
// Shared coordinate definitions for the snake game: field widths and pack/unpack helpers
// used by the segment buffer, controller and renderer.
package snake_pkg;

    localparam int unsigned X_W     = 6;
    localparam int unsigned Y_W     = 6;
    localparam int unsigned COORD_W = X_W + Y_W;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

    function automatic logic [COORD_W-1:0] pack_coord(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
        coord_t c;
        c.x = x;
        c.y = y;
        return c;
    endfunction

    function automatic coord_t unpack_coord(input logic [COORD_W-1:0] v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/seg_match_cmp.sv
// Any-match comparator: flags whether key equals any entry selected by mask.
module seg_match_cmp #(
    parameter int unsigned DataSize = 12,
    parameter int unsigned Depth    = 32
) (
    input  logic [Depth-1:0][DataSize-1:0] entries,
    input  logic [DataSize-1:0]            key,
    input  logic [Depth-1:0]               mask,
    output logic                           match_c
);

    always_comb begin
        match_c = 1'b0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (mask[i] && (entries[i] == key)) begin
                match_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_segment_buffer.sv
// Snake body storage: shift chain of coordinates (entry 0 = head) with growable length,
// random-access read port and registered self-collision flag.
module snake_segment_buffer
    import snake_pkg::*;
#(
    parameter int unsigned DataSize   = snake_pkg::COORD_W,
    parameter int unsigned Depth      = 32,
    parameter int unsigned InitLength = 3,
    localparam int unsigned LenWidth  = $clog2(Depth + 1),
    localparam int unsigned IdxWidth  = $clog2(Depth)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic [DataSize-1:0] init_data,
    input  logic                step,
    input  logic                grow,
    input  logic [DataSize-1:0] head_in,
    input  logic [IdxWidth-1:0] rd_idx,
    output logic [DataSize-1:0] rd_data,
    output logic                rd_valid,
    output logic [DataSize-1:0] head_q,
    output logic [DataSize-1:0] tail_q,
    output logic [LenWidth-1:0] length,
    output logic                full,
    output logic                hit
);

    logic [Depth-1:0][DataSize-1:0] entries;
    logic [LenWidth-1:0]            eff_len;
    logic [Depth-1:0]               cmp_mask;
    logic [IdxWidth-1:0]            tail_idx;
    logic                           can_grow;
    logic                           match_c;

    assign full     = (length == LenWidth'(Depth));
    assign can_grow = grow && !full;

    // The tail vacates its cell this move unless the snake grows into a free slot.
    assign eff_len = can_grow ? length : (length - LenWidth'(1));

    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            cmp_mask[i] = (LenWidth'(i) < eff_len);
        end
    end

    seg_match_cmp #(
        .DataSize (DataSize),
        .Depth    (Depth)
    ) u_match (
        .entries (entries),
        .key     (head_in),
        .mask    (cmp_mask),
        .match_c (match_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
            length  <= '0;
            hit     <= 1'b0;
        end else if (init) begin
            for (int i = 0; i < int'(Depth); i++) begin
                entries[i] <= (i < int'(InitLength)) ? init_data : '0;
            end
            length <= LenWidth'(InitLength);
            hit    <= 1'b0;
        end else if (step) begin
            entries <= {entries[Depth-2:0], head_in};
            if (length == '0) begin
                length <= LenWidth'(1);
                hit    <= 1'b0;
            end else begin
                if (can_grow) begin
                    length <= length + LenWidth'(1);
                end
                hit <= match_c;
            end
        end
    end

    assign tail_idx = IdxWidth'(length - LenWidth'(1));
    assign head_q   = entries[0];
    assign tail_q   = (length == '0) ? '0 : entries[tail_idx];
    assign rd_data  = entries[rd_idx];
    assign rd_valid = (LenWidth'(rd_idx) < length);

endmodule

// File: doc/snake_segment_buffer.md
Name: snake_segment_buffer

Overview:
- Parametrised successor to the single parallel-load register: a Depth-entry chain of DataSize-bit registers holding the snake body coordinates (entry 0 = head).
- Each step shifts a new head in and drops the tail. Growth extends the active length, saturating at Depth.
- Provides a random-access read port for the VGA renderer and a registered self-collision flag for the game controller.

Parameters:
- DataSize, 12, width of one packed coordinate {x,y}.
- Depth, 32, number of segment registers (maximum snake length), >=2.
- InitLength, 3, length loaded by init, 1..Depth.
- LenWidth, $clog2(Depth+1), localparam, width of length.
- IdxWidth, $clog2(Depth), localparam, width of rd_idx.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init  in  1  pulse: restart snake at init_data.
- init_data  in  DataSize  starting coordinate.
- step  in  1  pulse: advance one move.
- grow  in  1  qualifies step: extend length by one.
- head_in  in  DataSize  new head coordinate, sampled with step.
- rd_idx  in  IdxWidth  read index.
- rd_data  out  DataSize  entry[rd_idx], combinational.
- rd_valid  out  1  rd_idx < length, combinational.
- head_q  out  DataSize  entry[0].
- tail_q  out  DataSize  entry[length-1]; 0 when length==0.
- length  out  LenWidth  active segment count.
- full  out  1  length==Depth.
- hit  out  1  registered self-collision flag.

Behaviour:
- Reset (rst_n=0, async): every entry = 0, length = 0, hit = 0. Hence head_q = tail_q = 0, full = 0, rd_valid = 0.
- All state updates on posedge clk. Priority: init > step > hold. With neither init nor step, all registers hold (same semantics as the load=0 register).
- init:
  - entries 0..InitLength-1 <= init_data; remaining entries <= 0.
  - length <= InitLength; hit <= 0.
  - step and grow in the same cycle are ignored.
- step, length==0: entry[0] <= head_in; length <= 1; hit <= 0; grow ignored.
- step, length>0:
  - entry[i] <= entry[i-1] for i=1..Depth-1; entry[0] <= head_in. Entries at or beyond length are don't-care but must stay deterministic (shifted).
  - Length update: if grow and length<Depth, length <= length+1. If grow and full, length holds (saturate, no wrap). If no grow, length holds and the old tail falls out of the active range.
- hit, evaluated only on step with length>0 from pre-step contents:
  - eff = length if (grow and length<Depth), else length-1 (tail vacates this cycle).
  - hit <= 1 iff head_in == entry[i] for some i<eff; otherwise hit <= 0.
  - hit is valid the cycle after step (latency 1) and holds until the next step, init, or reset.
- Read port: rd_data is a purely combinational mux of current entries. It reflects a step one cycle after the step edge. rd_idx >= length gives stale data with rd_valid=0.
- Reset asserted mid-game clears state immediately; the first step after release behaves as the length==0 case.

Decomposition:
- Shared package snake_pkg: coordinate width constants (X_W, Y_W, DataSize = X_W+Y_W) and a coord pack/unpack function used by the controller and renderer.
- Sub-module seg_match_cmp: compares Depth entries against head_in under a length mask, returns a one-bit any-match. It is instantiated once; the sequential logic stays in the top.

Test Plan:
- Reset then idle: rst_n low mid-run with length=5 -> length=0, head_q=0, tail_q=0, hit=0 asynchronously, before the next clk edge.
- init with init_data=12'h123, InitLength=3 -> length=3. entry0..2 = 12'h123, rd_idx=3 gives rd_valid=0.
- Three steps with head_in 12'h124, 12'h125, 12'h126 and grow=0 -> length stays 3, head_q=12'h126, tail_q=12'h124. One step with grow=1 and head_in=12'h127 -> length=4, tail_q=12'h124.
- Saturation, Depth=4: five grow steps from length 0 -> length=4, full=1. A further grow step keeps length=4 and shifts the body.
- Collision with body: body {A,B,C,D}, step head_in=B, grow=0 -> hit=1 next cycle. Tail chase: step head_in=D (the tail), grow=0 -> hit=0. Same with grow=1 -> hit=1.
- init asserted together with step and grow=1 -> init wins: length=InitLength, hit=0, head_in discarded.
